frame_min_max: RTL and testbench

Streaming extrema accumulator that sits directly downstream of a data source and upstream of result consumers, reducing each frame of unsigned samples to its minimum, maximum and beat count. Samples arrive over a valid/ready stream with an end-of-frame marker. One registered result is presented per frame over a second valid/ready handshake. This block is the sequential, multi-sample counterpart to the library's two-input min/max comparator.

---
 rtl/frame_min_max_pkg.sv | 19 +
 rtl/frame_min_max_extrema_update.sv | 38 +++
 rtl/frame_min_max.sv | 135 +++++++++++++
 tb/tb_frame_min_max.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_min_max_pkg.sv
// -----------------------------------------------------------------------------
// frame_min_max_pkg
// Shared definitions for the frame extrema accumulator:
//   - default sample and beat-counter widths
//   - FSM state encoding used by the top level
// No ports; imported by frame_min_max and its sub-module.
// -----------------------------------------------------------------------------
package frame_min_max_pkg;

    localparam int DEFAULT_INPUT_BIT_WIDTH = 32;
    localparam int DEFAULT_COUNT_BIT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/frame_min_max_extrema_update.sv
// -----------------------------------------------------------------------------
// frame_min_max_extrema_update
// Purely combinational extrema step: folds one sample into a running
// minimum/maximum pair. Comparisons are unsigned and full width; a sample
// equal to the current extreme leaves that extreme unchanged.
//
// Ports:
//   cur_min  - current running minimum
//   cur_max  - current running maximum
//   sample   - new sample value
//   next_min - min(cur_min, sample)
//   next_max - max(cur_max, sample)
// -----------------------------------------------------------------------------
module frame_min_max_extrema_update
    import frame_min_max_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH = DEFAULT_INPUT_BIT_WIDTH
) (
    input  logic [INPUT_BIT_WIDTH-1:0] cur_min,
    input  logic [INPUT_BIT_WIDTH-1:0] cur_max,
    input  logic [INPUT_BIT_WIDTH-1:0] sample,
    output logic [INPUT_BIT_WIDTH-1:0] next_min,
    output logic [INPUT_BIT_WIDTH-1:0] next_max
);

    // Strict compares so that ties keep the existing register value.
    always_comb begin
        next_min = cur_min;
        next_max = cur_max;
        if (sample < cur_min) begin
            next_min = sample;
        end
        if (sample > cur_max) begin
            next_max = sample;
        end
    end

endmodule

// File: rtl/frame_min_max.sv
// -----------------------------------------------------------------------------
// frame_min_max
// Streaming extrema accumulator. Reduces each frame of unsigned samples,
// delivered over a valid/ready stream with an end-of-frame marker, to its
// minimum, maximum and (saturating) beat count. One registered result per
// frame is offered over a second valid/ready handshake.
//
// Ports:
//   Clk       - clock, rising edge active
//   Reset     - asynchronous, active-high reset
//   InValid   - sample on InData/InLast is valid
//   InReady   - block can accept a sample this cycle (state only)
//   InData    - sample value (unsigned)
//   InLast    - sample is the final beat of its frame
//   OutValid  - OutMin/OutMax/OutCount hold a completed frame result
//   OutReady  - consumer takes the result this cycle
//   OutMin    - frame minimum
//   OutMax    - frame maximum
//   OutCount  - beats in frame, saturating at all-ones
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame open; next accepted beat initialises the result
// ACCUM | frame open; accepted beats fold into min/max/count
// HOLD  | result presented on OutValid; input stalled until taken
// -----------------------------------------------------------------------------
module frame_min_max
    import frame_min_max_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH = DEFAULT_INPUT_BIT_WIDTH,
    parameter int COUNT_BIT_WIDTH = DEFAULT_COUNT_BIT_WIDTH
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [INPUT_BIT_WIDTH-1:0] InData,
    input  logic                       InLast,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [INPUT_BIT_WIDTH-1:0] OutMin,
    output logic [INPUT_BIT_WIDTH-1:0] OutMax,
    output logic [COUNT_BIT_WIDTH-1:0] OutCount
);

    state_t                     state;
    state_t                     state_next;
    logic [INPUT_BIT_WIDTH-1:0] min_q;
    logic [INPUT_BIT_WIDTH-1:0] max_q;
    logic [COUNT_BIT_WIDTH-1:0] count_q;
    logic [INPUT_BIT_WIDTH-1:0] upd_min;
    logic [INPUT_BIT_WIDTH-1:0] upd_max;
    logic                       in_ready;
    logic                       out_valid;
    logic                       accept;
    logic                       count_full;

    // Handshake flags come from the state register alone so InReady never
    // forms a combinational path from InValid.
    assign in_ready   = (state != HOLD);
    assign out_valid  = (state == HOLD);
    assign accept     = InValid && in_ready;
    assign count_full = &count_q;

    frame_min_max_extrema_update #(
        .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH)
    ) u_extrema_update (
        .cur_min  (min_q),
        .cur_max  (max_q),
        .sample   (InData),
        .next_min (upd_min),
        .next_max (upd_max)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = InLast ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    state_next = InLast ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The first beat of a frame seeds the result directly, so whatever was
    // left from the previous frame never leaks into the new one.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                min_q   <= InData;
                max_q   <= InData;
                count_q <= {{(COUNT_BIT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                min_q <= upd_min;
                max_q <= upd_max;
                if (!count_full) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign InReady  = in_ready;
    assign OutValid = out_valid;
    assign OutMin   = min_q;
    assign OutMax   = max_q;
    assign OutCount = count_q;

endmodule

// File: tb/tb_frame_min_max.sv
// -----------------------------------------------------------------------------
// tb_frame_min_max
// Self-checking bench for frame_min_max. Two instances share all inputs: the
// default-width one and one with a 2-bit beat counter for saturation.
// -----------------------------------------------------------------------------
module tb_frame_min_max;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         InValid = 1'b0;
    logic         InLast = 1'b0;
    logic         OutReady = 1'b0;
    logic [W-1:0] InData = '0;

    logic         InReady, OutValid;
    logic [W-1:0] OutMin, OutMax;
    logic [15:0]  OutCount;

    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_min, s_out_max;
    logic [1:0]   s_out_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    frame_min_max #(.INPUT_BIT_WIDTH(W), .COUNT_BIT_WIDTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InData(InData), .InLast(InLast), .OutValid(OutValid),
        .OutReady(OutReady), .OutMin(OutMin), .OutMax(OutMax),
        .OutCount(OutCount)
    );

    frame_min_max #(.INPUT_BIT_WIDTH(W), .COUNT_BIT_WIDTH(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(s_in_ready),
        .InData(InData), .InLast(InLast), .OutValid(s_out_valid),
        .OutReady(OutReady), .OutMin(s_out_min), .OutMax(s_out_max),
        .OutCount(s_out_count)
    );

    typedef struct {
        int              n;
        logic [3:0][W-1:0] d;
        int              gap;
        int              hold;
        logic [W-1:0]    emin;
        logic [W-1:0]    emax;
        logic [15:0]     ecnt;
        logic [1:0]      ecnt2;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [W-1:0] d, input logic last);
        int n;
        n = 0;
        @(negedge Clk);
        InValid = 1'b1;
        InData  = d;
        InLast  = last;
        while (!InReady && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("in_ready_wait", {63'd0, InReady}, 64'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    // Send a whole frame, then keep the result back-pressured for 'hold'
    // cycles while poking InValid, checking stability, then release it.
    task automatic run_frame(input logic [W-1:0] s [8], input int n, input int gap,
                             input int hold, input logic [W-1:0] emin,
                             input logic [W-1:0] emax, input logic [15:0] ecnt,
                             input logic [1:0] ecnt2);
        for (int i = 0; i < n; i++) begin
            send(s[i], (i == n - 1));
            if (i < n - 1) repeat (gap) @(posedge Clk);
        end
        for (int k = 0; k <= hold; k++) begin
            @(negedge Clk);
            chk("out_valid", {63'd0, OutValid}, 64'd1);
            chk("out_min", OutMin, emin);
            chk("out_max", OutMax, emax);
            chk("out_count", OutCount, ecnt);
            chk("in_ready_hold", {63'd0, InReady}, 64'd0);
            chk("sat_count", s_out_count, ecnt2);
            chk("sat_min", s_out_min, emin);
            chk("sat_valid", {63'd0, s_out_valid}, 64'd1);
            if (k == hold) begin
                OutReady = 1'b1;
                InValid  = 1'b0;
            end else begin
                InValid = (k % 2 == 0);
                InData  = $urandom;
                InLast  = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        InValid  = 1'b0;
        InLast   = 1'b0;
        @(negedge Clk);
        chk("out_valid_drop", {63'd0, OutValid}, 64'd0);
        chk("in_ready_back", {63'd0, InReady}, 64'd1);
    endtask

    function automatic vec_t mk(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input int gap, input int hold, input logic [W-1:0] emin,
                                input logic [W-1:0] emax, input logic [15:0] ecnt,
                                input logic [1:0] ecnt2);
        vec_t v;
        v.n = n;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d;
        v.gap = gap; v.hold = hold;
        v.emin = emin; v.emax = emax; v.ecnt = ecnt; v.ecnt2 = ecnt2;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [6];
        logic [W-1:0] buf8 [8];
        logic [W-1:0] ones;
        logic [W-1:0] rmin, rmax;
        int           rn;

        ones = '1;
        vecs[0] = mk(4, 5, 3, 9, 3, 0, 0, 3, 9, 4, 2'd3);
        vecs[1] = mk(1, 12, 0, 0, 0, 0, 0, 12, 12, 1, 2'd1);
        vecs[2] = mk(3, 100, 0, 1024, 0, 0, 10, 0, 1024, 3, 2'd3);
        vecs[3] = mk(3, 99, 100, 15, 0, 3, 0, 15, 100, 3, 2'd3);
        vecs[4] = mk(3, 7, 7, 7, 0, 1, 2, 7, 7, 3, 2'd3);
        vecs[5] = mk(2, ones, 0, 0, 0, 0, 1, 0, ones, 2, 2'd2);

        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, OutValid}, 64'd0);
        chk("rst_out_min", OutMin, 0);
        chk("rst_out_max", OutMax, 0);
        chk("rst_out_count", OutCount, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_in_ready", {63'd0, InReady}, 64'd1);
        chk("post_rst_out_valid", {63'd0, OutValid}, 64'd0);

        // Table-driven frames
        foreach (vecs[v]) begin
            for (int i = 0; i < 8; i++) buf8[i] = (i < 4) ? vecs[v].d[i] : '0;
            run_frame(buf8, vecs[v].n, vecs[v].gap, vecs[v].hold, vecs[v].emin,
                      vecs[v].emax, vecs[v].ecnt, vecs[v].ecnt2);
        end

        // Reset in the middle of a frame discards the partial result
        send(7, 1'b0);
        send(200, 1'b0);
        @(negedge Clk);
        Reset   = 1'b1;
        InValid = 1'b1;
        InData  = 999;
        #1;
        chk("midrst_min", OutMin, 0);
        chk("midrst_max", OutMax, 0);
        chk("midrst_count", OutCount, 0);
        chk("midrst_valid", {63'd0, OutValid}, 64'd0);
        @(posedge Clk);
        #1;
        chk("midrst_min_held", OutMin, 0);
        chk("midrst_count_held", OutCount, 0);
        @(negedge Clk);
        Reset   = 1'b0;
        InValid = 1'b0;
        @(negedge Clk);
        chk("midrst_in_ready", {63'd0, InReady}, 64'd1);
        chk("midrst_out_valid", {63'd0, OutValid}, 64'd0);
        buf8[0] = 50; buf8[1] = 60;
        run_frame(buf8, 2, 0, 0, 50, 60, 2, 2'd2);

        // Counter saturation: six all-ones beats then a zero
        for (int i = 0; i < 6; i++) buf8[i] = ones;
        buf8[6] = 0;
        run_frame(buf8, 7, 0, 1, 0, ones, 7, 2'd3);

        // Randomised frames against a plain min/max/count reference
        for (int f = 0; f < 30; f++) begin
            rn = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) begin
                buf8[i] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
            end
            rmin = buf8[0];
            rmax = buf8[0];
            for (int i = 1; i < rn; i++) begin
                if (buf8[i] < rmin) rmin = buf8[i];
                if (buf8[i] > rmax) rmax = buf8[i];
            end
            run_frame(buf8, rn, $urandom_range(0, 2), $urandom_range(0, 3), rmin, rmax,
                      16'(rn), (rn > 3) ? 2'd3 : 2'(rn));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
